booth_mult: RTL and testbench

Sequential signed radix-2 Booth multiplier that produces the write data and write strobe for a downstream `nbit_reg`. It accepts two `DATA_WIDTH`-bit signed operands on a start pulse and iterates one Booth step per clock. It then presents the full-width product for one `Write` cycle, so the low half can be captured directly into an `nbit_reg` through its `nD` and `Write` inputs. It is the multiply stage that feeds the datapath result registers.

---
 rtl/booth_mult.sv | 130 +++++++++++++
 tb/tb_booth_mult.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_mult: sequential signed radix-2 Booth multiplier, one step per clock. |
// | Optional macro BOOTH_MULT_OVF_EN enables the registered Ovf flag.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module booth_mult #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Write,
    output logic [DATA_WIDTH-1:0] ResultLo,
    output logic [DATA_WIDTH-1:0] ResultHi,
    output logic                  Ovf
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [DATA_WIDTH:0]     acc;
    logic                    q_m1;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH-1:0]   result_lo;
    logic [DATA_WIDTH-1:0]   result_hi;

    logic [DATA_WIDTH:0]     mcand_ext;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     acc_shifted;
    logic [DATA_WIDTH-1:0]   mplier_shifted;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    last_step;

    // One Booth step; the extra accumulator bit keeps -2^(W-1) exact.
    always_comb begin
        mcand_ext = {mcand[DATA_WIDTH-1], mcand};
        case ({mplier[0], q_m1})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
        acc_shifted    = {sum[DATA_WIDTH], sum[DATA_WIDTH:1]};
        mplier_shifted = {sum[0], mplier[DATA_WIDTH-1:1]};
        product        = {acc_shifted[DATA_WIDTH-1:0], mplier_shifted};
        last_step      = (count == LAST_STEP);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_RUN;
            S_RUN:   if (last_step) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state != S_IDLE);
        Write = (state == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else if (state == S_IDLE && Start) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
        end else if (state == S_RUN) begin
            acc    <= acc_shifted;
            mplier <= mplier_shifted;
            q_m1   <= mplier[0];
            count  <= count + 1'b1;
            if (last_step) begin
                result_lo <= product[DATA_WIDTH-1:0];
                result_hi <= product[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    assign ResultLo = result_lo;
    assign ResultHi = result_hi;

`ifdef BOOTH_MULT_OVF_EN
    logic ovf_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
        end else if (state == S_RUN && last_step) begin
            ovf_q <= (product[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{product[DATA_WIDTH-1]}});
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_booth_mult: directed bench for booth_mult with a cycle-level model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_booth_mult;

    localparam int W = 32;
`ifdef BOOTH_MULT_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Write;
    logic [W-1:0] ResultLo;
    logic [W-1:0] ResultHi;
    logic         Ovf;

    booth_mult #(.DATA_WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Write    (Write),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .Ovf      (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Downstream nbit_reg: captures ResultLo whenever Write is high.
    logic [W-1:0] nreg;
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) nreg <= '0;
        else if (Write) nreg <= ResultLo;
    end

    // Model: timing expressed as edge distance from the accepting edge.
    bit           m_active = 1'b0;
    int           m_acc_e  = 0;
    int           edge_cnt = 0;
    longint       m_prod   = 0;
    logic [W-1:0] m_lo     = '0;
    logic [W-1:0] m_hi     = '0;
    logic         m_ovf    = 1'b0;

    initial begin
        forever begin
            @(posedge Clk or negedge Reset);
            if (!Reset) begin
                m_active = 1'b0;
                m_lo     = '0;
                m_hi     = '0;
                m_ovf    = 1'b0;
            end else if (Clk) begin
                edge_cnt++;
                if (m_active && (edge_cnt - m_acc_e) == W) begin
                    m_lo  = m_prod[W-1:0];
                    m_hi  = m_prod[2*W-1:W];
                    m_ovf = OVF_ON && (m_prod < -(64'sd1 <<< (W-1)) || m_prod >= (64'sd1 <<< (W-1)));
                end
                if ((!m_active || (edge_cnt - 1 - m_acc_e) >= W + 1) && Start) begin
                    m_active = 1'b1;
                    m_acc_e  = edge_cnt;
                    m_prod   = longint'($signed(A)) * longint'($signed(B));
                end
            end
        end
    end

    initial begin
        logic exp_busy;
        logic exp_write;
        int   d;
        forever begin
            @(negedge Clk);
            cyc++;
            d         = edge_cnt - m_acc_e;
            exp_busy  = m_active && (d <= W);
            exp_write = m_active && (d == W);
            n_checks++;
            if (Busy !== exp_busy || Write !== exp_write || ResultLo !== m_lo ||
                ResultHi !== m_hi || Ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL cycle %0d: got busy=%b write=%b ovf=%b lo=%h hi=%h, want busy=%b write=%b ovf=%b lo=%h hi=%h",
                         cyc, Busy, Write, Ovf, ResultLo, ResultHi,
                         exp_busy, exp_write, m_ovf, m_lo, m_hi);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        #1;
        Start = 1'b1;
        A     = a;
        B     = b;
        @(negedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_write(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Write && n < 100);
        if (!Write) check("write_timeout", 64'(Write), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lo, input logic [W-1:0] hi, input logic ovf);
        int n;
        start_op(a, b);
        wait_write(n);
        check({name, "_latency"}, 64'(n), 64'd32);
        check({name, "_lo"}, 64'(ResultLo), 64'(lo));
        check({name, "_hi"}, 64'(ResultHi), 64'(hi));
        check({name, "_ovf"}, 64'(Ovf), 64'(ovf));
        @(negedge Clk);
        check({name, "_write_one_cycle"}, 64'(Write), 64'd0);
        check({name, "_nreg"}, 64'(nreg), 64'(lo));
    endtask

    initial begin
        int n;
        int wcount;
        logic [W-1:0] wlo;
        int widx[3];
        int k;

        Reset = 1'b0;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {Busy, Write, Ovf, ResultLo, ResultHi}, '0);
        #1 Reset = 1'b1;

        run_op("pos_6x7", 32'd6, 32'd7, 32'h0000002A, 32'h0, 1'b0);
        run_op("neg_m3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0);
        run_op("neg_m7xm9", 32'hFFFFFFF9, 32'hFFFFFFF7, 32'h0000003F, 32'h0, 1'b0);
        run_op("most_neg", 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, OVF_ON);

        // Second Start arrives at edge 10 while busy and must be ignored.
        start_op(32'd2, 32'd3);
        repeat (9) @(negedge Clk);
        #1;
        Start = 1'b1;
        A     = 32'd9;
        B     = 32'd9;
        @(negedge Clk);
        #1 Start = 1'b0;
        wcount = 0;
        wlo    = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Write) begin
                wcount++;
                wlo = ResultLo;
            end
        end
        check("busy_ignore_writes", 64'(wcount), 64'd1);
        check("busy_ignore_lo", 64'(wlo), 64'd6);

        // Abort mid-operation.
        start_op(32'd5, 32'd5);
        repeat (14) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_outputs_zero", {Busy, Write, Ovf, ResultLo, ResultHi}, '0);
        @(negedge Clk);
        @(negedge Clk);
        #1 Reset = 1'b1;
        wcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Write) wcount++;
        end
        check("abort_no_write", 64'(wcount), 64'd0);
        run_op("after_abort_4x4", 32'd4, 32'd4, 32'd16, 32'h0, 1'b0);

        run_op("ovf_2p16", 32'h00010000, 32'h00010000, 32'h0, 32'h1, OVF_ON);

        // Start held high: one Write every W+2 cycles.
        @(negedge Clk);
        #1;
        Start = 1'b1;
        A     = 32'h00010000;
        B     = 32'h00010000;
        k     = 0;
        n     = 0;
        while (k < 3 && n < 300) begin
            @(negedge Clk);
            n++;
            if (Write) begin
                widx[k] = n;
                k++;
            end
        end
        #1 Start = 1'b0;
        check("held_start_writes", 64'(k), 64'd3);
        if (k == 3) begin
            check("held_start_spacing1", 64'(widx[1] - widx[0]), 64'd34);
            check("held_start_spacing2", 64'(widx[2] - widx[1]), 64'd34);
        end
        repeat (40) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
